uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive side of the UART peripheral. The asynchronous serial line is
// synchronized into the clock domain, 8N1 characters are deframed by
// counting system clocks per bit and sampling each bit at its centre,
// and completed bytes are queued in a small show-ahead FIFO that drains
// over a valid/ready handshake.
//
// Ports
//   clock      system clock, all logic on the rising edge
//   reset      asynchronous, active-low reset
//   uart_rx    serial line, idle high, asynchronous to clock
//   rx_data    FIFO head byte (0 when the FIFO is empty)
//   rx_valid   FIFO not empty
//   rx_ready   consumer accepts the head byte when rx_valid && rx_ready
//   rx_count   number of bytes currently stored, 0..depth
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: byte completed while FIFO full, byte dropped
//
// Receiver states
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | line high, waiting for a falling edge
//   START     | half-bit timer running, confirming the start bit
//   DATA      | sampling 8 data bits LSB first at bit centres
//   STOP      | waiting for the stop-bit centre
//   WAIT_HIGH | stop bit was low; hold off until the line returns high

module uart_rx_fifo #(
  parameter int clks_per_bit = 868,
  parameter int depth        = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     uart_rx,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [$clog2(depth):0]   rx_count,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(clks_per_bit);

  localparam logic [cw-1:0] bit_reload  = cw'(clks_per_bit - 1);
  localparam logic [cw-1:0] half_reload = cw'(clks_per_bit / 2 - 1);
  localparam logic [aw:0]   full_count  = (aw + 1)'(depth);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  // --------------------------------------------------------------------
  // Input synchronizer; resets to the idle (high) line level so that
  // leaving reset never looks like a start bit.
  // --------------------------------------------------------------------
  logic sync1, sync2, rxs;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      sync2 <= sync1;
    end
  end

  assign rxs = sync2;

  // --------------------------------------------------------------------
  // Deframer
  // --------------------------------------------------------------------
  state_t        state;
  logic [cw-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          expired;
  logic          push;

  assign expired = (cnt == '0);

  // The byte is handed to the FIFO on the stop-sample edge itself, so
  // the push request is decoded from the current state rather than
  // registered; that makes rx_valid rise in the cycle right after it.
  assign push = (state == STOP) && expired && rxs;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= half_reload;
          end
        end

        START: begin
          if (expired) begin
            if (!rxs) begin
              state   <= DATA;
              cnt     <= bit_reload;
              bit_idx <= '0;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (expired) begin
            shreg <= {rxs, shreg[7:1]};
            cnt   <= bit_reload;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        STOP: begin
          if (expired) begin
            if (rxs) begin
              // Returning to IDLE at mid-stop leaves half a bit of
              // margin before a back-to-back start edge.
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        WAIT_HIGH: begin
          // A held-low line (break) must not be decoded as 0x00 bytes.
          if (rxs) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------
  logic [7:0]    mem [depth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic          pop;
  logic          accept;
  logic          full;

  assign full     = (rx_count == full_count);
  assign rx_valid = (rx_count != '0);
  assign pop      = rx_valid && rx_ready;

  // A push into a full FIFO still fits when the head leaves in the same
  // cycle, since the freed slot is exactly the one being written.
  assign accept   = push && (!full || pop);

  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= push && full && !pop;

      if (accept) begin
        wr_ptr <= wr_ptr + aw'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + aw'(1);
      end

      case ({accept, pop})
        2'b10:   rx_count <= rx_count + (aw + 1)'(1);
        2'b01:   rx_count <= rx_count - (aw + 1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

endmodule
